// File: rtl/dmem_arbiter_pkg.sv
// Shared encodings for the data-memory arbiter: FSM states and requester IDs.
// Latency: n/a (types only). Backpressure: n/a.
package dmem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SERVE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

endpackage

// File: rtl/dmem_arbiter_pick.sv
// Two-way round-robin picker: lock holder first, else prio on contention, else the lone requester.
// Latency: combinational. Backpressure: none; a losing request simply stays pending upstream.
module rr_pick2
    import dmem_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       prio,
    input  logic       lock_hold,
    output logic       gnt_id,
    output logic       gnt_valid
);

    always_comb begin
        gnt_valid = |req;
        gnt_id    = PORT_A;
        if (lock_hold && req[prio]) begin
            gnt_id = prio;
        end else if (req == 2'b11) begin
            gnt_id = prio;
        end else if (req[1]) begin
            gnt_id = PORT_B;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates a single-port data memory between ports A and B, one transaction at a time.
// Latency: 3 cycles per transaction (IDLE grant, SERVE access, RESP ack). Backpressure: req held until ack.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int ADDR_W   = 4,
    parameter int DATA_W   = 8,
    parameter int LOCK_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_req,
    input  logic              a_we,
    input  logic              a_lock,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_ack,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_req,
    input  logic              b_we,
    input  logic              b_lock,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_ack,
    output logic [DATA_W-1:0] b_rdata,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int CNT_W = $clog2(LOCK_MAX + 1);

    state_t            state, state_nxt;
    logic              owner, owner_lock, prio, we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [CNT_W-1:0]  lock_cnt;

    logic [1:0] req;
    logic       owner_req, lock_at_max, lock_hold, pick_prio;
    logic       gnt_id, gnt_valid, grab, serve;

    assign req         = {b_req, a_req};
    assign owner_req   = (owner == PORT_B) ? b_req : a_req;
    assign lock_at_max = owner_lock && (lock_cnt == CNT_W'(LOCK_MAX));
    assign lock_hold   = owner_lock && owner_req && !lock_at_max;
    // An exhausted lock hands priority to the other port for this one pick.
    assign pick_prio   = lock_hold ? owner : (lock_at_max ? ~owner : prio);
    assign grab        = (state == ST_IDLE) && gnt_valid;
    assign serve       = (state == ST_SERVE);

    rr_pick2 u_pick (
        .req       (req),
        .prio      (pick_prio),
        .lock_hold (lock_hold),
        .gnt_id    (gnt_id),
        .gnt_valid (gnt_valid)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = ST_IDLE;
        case (state)
            ST_IDLE:  state_nxt = gnt_valid ? ST_SERVE : ST_IDLE;
            ST_SERVE: state_nxt = ST_RESP;
            ST_RESP:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        mem_read  = serve && !we_q;
        mem_write = serve && we_q;
        mem_addr  = serve ? addr_q  : '0;
        mem_wdata = serve ? wdata_q : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner      <= PORT_A;
            owner_lock <= 1'b0;
            prio       <= PORT_A;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            lock_cnt   <= '0;
        end else if (grab) begin
            owner      <= gnt_id;
            owner_lock <= (gnt_id == PORT_B) ? b_lock  : a_lock;
            we_q       <= (gnt_id == PORT_B) ? b_we    : a_we;
            addr_q     <= (gnt_id == PORT_B) ? b_addr  : a_addr;
            wdata_q    <= (gnt_id == PORT_B) ? b_wdata : a_wdata;
            lock_cnt   <= lock_hold ? lock_cnt + CNT_W'(1) : '0;
            if (!lock_hold && (req == 2'b11)) begin
                prio <= ~gnt_id;
            end
        end else if (state == ST_IDLE) begin
            lock_cnt <= '0;
        end
    end

    // Ack and read data land together at the SERVE->RESP edge; rdata holds until the next read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_ack   <= 1'b0;
            b_ack   <= 1'b0;
            a_rdata <= '0;
            b_rdata <= '0;
        end else begin
            a_ack <= serve && (owner == PORT_A);
            b_ack <= serve && (owner == PORT_B);
            if (serve && !we_q && (owner == PORT_A)) begin
                a_rdata <= mem_rdata;
            end
            if (serve && !we_q && (owner == PORT_B)) begin
                b_rdata <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter with a behavioural 16x8 memory, per-port drivers and an ack scoreboard.
module tb_dmem_arbiter;

    localparam logic PA = 1'b0;
    localparam logic PB = 1'b1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       a_req, a_we, a_lock, a_ack;
    logic [3:0] a_addr;
    logic [7:0] a_wdata, a_rdata;
    logic       b_req, b_we, b_lock, b_ack;
    logic [3:0] b_addr;
    logic [7:0] b_wdata, b_rdata;
    logic       mem_read, mem_write;
    logic [3:0] mem_addr;
    logic [7:0] mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_W(4), .DATA_W(8), .LOCK_MAX(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_req(a_req), .a_we(a_we), .a_lock(a_lock), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_ack(a_ack), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_lock(b_lock), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_ack(b_ack), .b_rdata(b_rdata),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // data_mem model: preloaded on the first clock (inside reset), combinational read gated by memread
    logic [7:0] mem [16];
    logic       mem_init_done = 1'b0;
    assign mem_rdata = mem_read ? mem[mem_addr] : 8'd0;

    always @(posedge clk) begin
        if (!mem_init_done) begin
            for (int i = 0; i < 16; i++) mem[i] <= 8'd0;
            mem[0] <= 8'd10;
            mem[1] <= 8'd10;
            mem_init_done <= 1'b1;
        end else if (mem_write) begin
            mem[mem_addr] <= mem_wdata;
        end
    end

    typedef struct packed {
        logic       we;
        logic       lock;
        logic [3:0] addr;
        logic [7:0] wdata;
    } cmd_t;

    typedef struct packed {
        logic       port;
        logic [7:0] rdata;
    } exp_t;

    typedef struct {
        int         grp;
        logic       port;
        logic       we;
        logic       lock;
        logic [3:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp_rdata;
    } vec_t;

    cmd_t aq[$];
    cmd_t bq[$];
    exp_t sb[$];
    vec_t vecs[$];
    cmd_t ca, cb;
    exp_t me;
    logic a_busy, b_busy;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   ack_cyc_a = 0;
    int   ack_cyc_b = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Port drivers: present the next queued command on the negedge the previous one is acked.
    initial begin
        a_req = 0; a_we = 0; a_lock = 0; a_addr = 0; a_wdata = 0; a_busy = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                a_req = 0; a_busy = 0; aq.delete();
            end else if (!a_busy || a_ack) begin
                if (aq.size() > 0) begin
                    ca = aq.pop_front();
                    a_req = 1; a_we = ca.we; a_lock = ca.lock; a_addr = ca.addr; a_wdata = ca.wdata;
                    a_busy = 1;
                end else begin
                    a_req = 0; a_lock = 0; a_busy = 0;
                end
            end
        end
    end

    initial begin
        b_req = 0; b_we = 0; b_lock = 0; b_addr = 0; b_wdata = 0; b_busy = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                b_req = 0; b_busy = 0; bq.delete();
            end else if (!b_busy || b_ack) begin
                if (bq.size() > 0) begin
                    cb = bq.pop_front();
                    b_req = 1; b_we = cb.we; b_lock = cb.lock; b_addr = cb.addr; b_wdata = cb.wdata;
                    b_busy = 1;
                end else begin
                    b_req = 0; b_lock = 0; b_busy = 0;
                end
            end
        end
    end

    // Ack monitor: every ack must match the head of the scoreboard (port order and read data).
    always @(negedge clk) begin
        if (a_ack || b_ack) begin
            chk("ack_exclusive", {31'd0, a_ack && b_ack}, 32'd0);
            if (sb.size() == 0) begin
                chk("unexpected_ack", {31'd0, b_ack}, 32'hFFFF_FFFF);
            end else begin
                me = sb.pop_front();
                chk("ack_port", {31'd0, b_ack}, {31'd0, me.port});
                chk("ack_rdata", {24'd0, (b_ack ? b_rdata : a_rdata)}, {24'd0, me.rdata});
                if (a_ack) ack_cyc_a = cyc;
                if (b_ack) ack_cyc_b = cyc;
            end
        end
    end

    task automatic check_outputs_zero(input string name);
        chk(name, {a_ack, b_ack, mem_read, mem_write, mem_addr, mem_wdata, a_rdata, b_rdata}, 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 0;
        #1;
        check_outputs_zero("reset_outputs");
        repeat (2) @(negedge clk);
        rst_n = 1;
    endtask

    task automatic add_vec(input int g, input logic p, input logic we, input logic lk,
                           input logic [3:0] ad, input logic [7:0] wd, input logic [7:0] rd);
        vec_t v;
        v.grp = g; v.port = p; v.we = we; v.lock = lk; v.addr = ad; v.wdata = wd; v.exp_rdata = rd;
        vecs.push_back(v);
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((sb.size() != 0 || aq.size() != 0 || bq.size() != 0 || a_busy || b_busy) && n < 300) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk(name, {31'd0, n < 300}, 32'd1);
        repeat (2) @(negedge clk);
    endtask

    // Table rows are listed in expected grant order; commands go to port queues in row order.
    task automatic run_group(input int g);
        cmd_t c;
        exp_t e;
        foreach (vecs[i]) begin
            if (vecs[i].grp == g) begin
                c.we = vecs[i].we; c.lock = vecs[i].lock; c.addr = vecs[i].addr; c.wdata = vecs[i].wdata;
                if (vecs[i].port == PB) bq.push_back(c);
                else aq.push_back(c);
                e.port = vecs[i].port; e.rdata = vecs[i].exp_rdata;
                sb.push_back(e);
            end
        end
        wait_drain($sformatf("drain_grp%0d", g));
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int   n;
        int   rd_cnt;
        int   ack_at;
        cmd_t c;
        exp_t e;

        //       grp port we lock addr  wdata   exp_rdata
        add_vec(2, PA, 1, 0, 4'd3, 8'h5A, 8'h00);
        add_vec(2, PB, 0, 0, 4'd3, 8'h00, 8'h5A);
        add_vec(3, PA, 1, 0, 4'd4, 8'h11, 8'h00);
        add_vec(3, PB, 0, 0, 4'd4, 8'h00, 8'h11);
        add_vec(3, PA, 1, 0, 4'd5, 8'h22, 8'h00);
        add_vec(3, PB, 0, 0, 4'd5, 8'h00, 8'h22);
        add_vec(3, PA, 1, 0, 4'd6, 8'h33, 8'h00);
        add_vec(3, PB, 0, 0, 4'd6, 8'h00, 8'h33);
        add_vec(4, PA, 0, 1, 4'd1, 8'h00, 8'd10);
        add_vec(4, PA, 1, 1, 4'd1, 8'd11, 8'd10);
        add_vec(4, PA, 0, 1, 4'd1, 8'h00, 8'd11);
        add_vec(4, PA, 1, 1, 4'd7, 8'h77, 8'd11);
        add_vec(4, PA, 0, 1, 4'd1, 8'h00, 8'd11);
        add_vec(4, PB, 0, 0, 4'd1, 8'h00, 8'd11);
        add_vec(4, PA, 0, 0, 4'd7, 8'h00, 8'h77);
        add_vec(6, PA, 0, 0, 4'd0, 8'h00, 8'd10);
        add_vec(6, PA, 1, 0, 4'd8, 8'h88, 8'd10);
        add_vec(5, PA, 0, 0, 4'd0, 8'h00, 8'd10);
        add_vec(5, PB, 0, 0, 4'd0, 8'h00, 8'd10);

        // 1: single A read, cycle-level timing
        do_reset();
        c.we = 0; c.lock = 0; c.addr = 4'd0; c.wdata = 8'd0;
        aq.push_back(c);
        e.port = PA; e.rdata = 8'd10;
        sb.push_back(e);
        n = 0;
        while (!a_req && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("t1_req_seen", {31'd0, a_req}, 32'd1);
        rd_cnt = 0;
        ack_at = 0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            #1;
            if (mem_read) rd_cnt++;
            if (a_ack && ack_at == 0) ack_at = k;
            if (k == 1) chk("t1_serve_read", {27'd0, mem_read, mem_addr}, {27'd0, 1'b1, 4'd0});
        end
        chk("t1_read_pulse", rd_cnt, 1);
        chk("t1_ack_latency", ack_at, 2);
        wait_drain("drain_t1");
        chk("t1_rdata", {24'd0, a_rdata}, 32'd10);

        // 2: simultaneous A write / B read of the same address
        do_reset();
        run_group(2);
        chk("t2_ack_gap", ack_cyc_b - ack_cyc_a, 3);

        // 3: continuous contention alternates
        do_reset();
        run_group(3);

        // 4: locked RMW run, forced hand-off after LOCK_MAX
        do_reset();
        run_group(4);
        chk("t4_mem1", {24'd0, mem[1]}, 32'd11);

        // 6: read data is held across a later write ack
        do_reset();
        run_group(6);
        chk("t6_rdata_hold", {24'd0, a_rdata}, 32'd10);

        // 5: reset during SERVE of a B write
        do_reset();
        c.we = 1; c.lock = 0; c.addr = 4'd2; c.wdata = 8'hFF;
        bq.push_back(c);
        n = 0;
        while (!mem_write && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("t5_in_serve", {27'd0, mem_write, mem_addr}, {27'd0, 1'b1, 4'd2});
        rst_n = 0;
        #1;
        check_outputs_zero("t5_reset_outputs");
        repeat (2) @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        #1;
        chk("t5_mem2_untouched", {24'd0, mem[2]}, 32'd0);
        run_group(5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
